// File: rtl/branch_hazard_ctrl.sv
// Branch operand hazard controller: stalls a branch/JALR in ID until its sources can be forwarded into ID.
// Optional stall-cycle counter is built only when BRANCH_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | no branch waiting; evaluates hazards for the ID branch
// STALL | branch waiting out a fixed stall count (cnt = stalls still to issue)
module branch_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_branch,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic             i_mem_mem_read,
  input  logic             i_branch_taken,
  input  logic             i_hold,
  input  logic             i_kill,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_resolve,
  output logic             o_flush_if_id,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need;
  logic       ex_hit, mem_hit;

  // Writes to x0 are discarded, so they never create a dependency.
  assign ex_hit  = i_ex_reg_write && (i_ex_rd != 5'd0) &&
                   ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  assign mem_hit = i_mem_reg_write && (i_mem_rd != 5'd0) &&
                   ((i_mem_rd == i_id_rs1) || (i_mem_rd == i_id_rs2));

  always_comb begin
    need = 2'd0;
    if (ex_hit && i_ex_mem_read) begin
      need = 2'd2;
    end else if (ex_hit || (mem_hit && i_mem_mem_read)) begin
      need = 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_stall       = 1'b0;
    o_bubble      = 1'b0;
    o_resolve     = 1'b0;
    o_flush_if_id = 1'b0;
    if (i_kill) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_id_branch) begin
            if (need == 2'd0) begin
              o_resolve     = !i_hold;
              o_flush_if_id = i_branch_taken && !i_hold;
            end else begin
              o_stall  = 1'b1;
              o_bubble = 1'b1;
              if (!i_hold) begin
                state_d = STALL;
                cnt_d   = need - 2'd1;
              end
            end
          end
        end
        STALL: begin
          // Count was fixed on entry; hazard inputs are deliberately ignored here.
          if (cnt_q != 2'd0) begin
            o_stall  = 1'b1;
            o_bubble = 1'b1;
            if (!i_hold) cnt_d = cnt_q - 2'd1;
          end else begin
            o_resolve     = !i_hold;
            o_flush_if_id = i_branch_taken && !i_hold;
            if (!i_hold) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  assign o_busy = (state_q == STALL) && !i_kill;

`ifdef BRANCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
    end else if (o_stall && !i_hold && !i_kill) begin
      stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_stall_cycles = stall_cycles_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus randomized traffic vs a stall-accounting model.
module tb_branch_hazard_ctrl;
  localparam int CNT_W = 32;
`ifdef BRANCH_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_branch, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
  logic branch_taken, hold, kill;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic o_stall, o_bubble, o_resolve, o_flush_if_id, o_busy;
  logic [CNT_W-1:0] o_stall_cycles;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_branch(id_branch), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read),
    .i_mem_rd(mem_rd), .i_mem_reg_write(mem_reg_write), .i_mem_mem_read(mem_mem_read),
    .i_branch_taken(branch_taken), .i_hold(hold), .i_kill(kill),
    .o_stall(o_stall), .o_bubble(o_bubble), .o_resolve(o_resolve),
    .o_flush_if_id(o_flush_if_id), .o_busy(o_busy), .o_stall_cycles(o_stall_cycles)
  );

  int errors = 0;
  int checks = 0;

  // Model: a branch "in flight" has a stall requirement and a tally of stalls already issued.
  bit               m_inflight;
  int               m_need;
  int               m_done;
  logic [CNT_W-1:0] m_cnt;

  logic a_stall, a_res, a_flush, a_busy;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int need_of();
    int n = 0;
    logic [4:0] srcs [2];
    srcs[0] = id_rs1;
    srcs[1] = id_rs2;
    if (!id_branch) return 0;
    foreach (srcs[i]) begin
      if (ex_reg_write && ex_rd != 0 && ex_rd == srcs[i]) n = (ex_mem_read ? 2 : ((n > 1) ? n : 1));
      if (mem_reg_write && mem_mem_read && mem_rd != 0 && mem_rd == srcs[i] && n < 1) n = 1;
    end
    return n;
  endfunction

  task automatic model_out(input int n, output bit e_stall, output bit e_res,
                           output bit e_flush, output bit e_busy);
    e_stall = 0; e_res = 0; e_flush = 0; e_busy = 0;
    if (!kill) begin
      e_busy = m_inflight;
      if (!m_inflight) begin
        if (n > 0) e_stall = 1;
        else if (id_branch) begin e_res = !hold; e_flush = branch_taken && !hold; end
      end else if (m_done < m_need) begin
        e_stall = 1;
      end else begin
        e_res = !hold; e_flush = branch_taken && !hold;
      end
    end
  endtask

  task automatic model_step(input int n, input bit e_stall);
    if (kill) begin
      m_inflight = 0;
    end else if (!hold) begin
      if (CNT_EN && e_stall) m_cnt = m_cnt + 1;
      if (!m_inflight) begin
        if (n > 0) begin m_inflight = 1; m_need = n; m_done = 1; end
      end else if (m_done < m_need) begin
        m_done++;
      end else begin
        m_inflight = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit e_stall, e_res, e_flush, e_busy;
    int n;
    @(negedge clk);
    n = need_of();
    model_out(n, e_stall, e_res, e_flush, e_busy);
    a_stall = o_stall; a_res = o_resolve; a_flush = o_flush_if_id; a_busy = o_busy;
    check("stall", o_stall, e_stall);
    check("bubble", o_bubble, e_stall);
    check("resolve", o_resolve, e_res);
    check("flush", o_flush_if_id, e_flush);
    check("busy", o_busy, e_busy);
    check("stall_cycles", o_stall_cycles, m_cnt);
    @(posedge clk);
    model_step(n, e_stall);
    #1;
  endtask

  task automatic quiet();
    id_branch = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0;
    branch_taken = 0; hold = 0; kill = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    check("rst_stall", o_stall, 0);
    check("rst_resolve", o_resolve, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cnt", o_stall_cycles, 0);
    m_inflight = 0; m_need = 0; m_done = 0; m_cnt = '0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    m_inflight = 0; m_need = 0; m_done = 0; m_cnt = '0;
    #1;
    do_reset();

    // EX load on rs1: two stalls then resolve, counter 2
    id_branch = 1; id_rs1 = 5; ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
    tick(); check("ld_c0_stall", a_stall, 1);
    ex_reg_write = 0; ex_mem_read = 0;
    tick(); check("ld_c1_stall", a_stall, 1);
    tick(); check("ld_c2_stall", a_stall, 0); check("ld_c2_res", a_res, 1);
    check("ld_cnt", o_stall_cycles, CNT_EN ? 2 : 0);
    quiet(); tick();

    // EX ALU on rs2, taken: one stall then resolve with flush
    do_reset();
    id_branch = 1; id_rs2 = 7; ex_rd = 7; ex_reg_write = 1; branch_taken = 1;
    tick(); check("alu_c0_stall", a_stall, 1);
    ex_reg_write = 0;
    tick(); check("alu_c1_res", a_res, 1); check("alu_c1_flush", a_flush, 1);
    quiet(); tick();

    // x0 match: resolves at once; MEM load on rs2: one stall
    id_branch = 1; ex_reg_write = 1; ex_mem_read = 1;
    tick(); check("x0_res", a_res, 1); check("x0_stall", a_stall, 0);
    quiet(); id_branch = 1; id_rs2 = 3; mem_rd = 3; mem_reg_write = 1; mem_mem_read = 1;
    tick(); check("mem_c0_stall", a_stall, 1);
    mem_reg_write = 0;
    tick(); check("mem_c1_res", a_res, 1);
    quiet(); id_rs1 = 4; ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1;
    tick(); check("nobranch_stall", a_stall, 0);
    quiet(); tick();

    // Hold for three cycles in STALL
    do_reset();
    id_branch = 1; id_rs1 = 5; ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
    tick();
    ex_reg_write = 0; ex_mem_read = 0; hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("hold_stall", a_stall, 1); check("hold_res", a_res, 0);
    end
    hold = 0;
    tick(); check("hold_c4_stall", a_stall, 1);
    tick(); check("hold_c5_res", a_res, 1);
    check("hold_cnt", o_stall_cycles, CNT_EN ? 2 : 0);
    quiet(); tick();

    // Kill in first STALL cycle
    do_reset();
    id_branch = 1; id_rs1 = 6; ex_rd = 6; ex_reg_write = 1; ex_mem_read = 1;
    tick();
    ex_reg_write = 0; ex_mem_read = 0; kill = 1;
    tick(); check("kill_stall", a_stall, 0); check("kill_busy", a_busy, 0);
    kill = 0; id_branch = 0;
    tick(); check("kill_after_busy", a_busy, 0); check("kill_after_res", a_res, 0);

    // Reset mid-STALL
    id_branch = 1; id_rs1 = 6; ex_rd = 6; ex_reg_write = 1; ex_mem_read = 1;
    tick();
    quiet();
    do_reset();
    tick(); check("rst_after_busy", a_busy, 0); check("rst_after_res", a_res, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      id_branch = ($urandom_range(0, 2) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = $urandom_range(0, 1) == 1;
      ex_mem_read = $urandom_range(0, 1) == 1;
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = $urandom_range(0, 1) == 1;
      mem_mem_read = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 1) == 1;
      hold = ($urandom_range(0, 4) == 0);
      kill = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
